// File: rtl/wb_single_master.sv
// Single-transaction Wishbone classic master: one request -> one bus cycle,
// with a one-cycle done pulse (plus data-valid pulse for reads).
module wb_single_master #(
    parameter int ADDR_WIDTH = 3,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    output logic [ADDR_WIDTH-1:0] o_wbs_adr,
    output logic [DATA_WIDTH-1:0] o_wbs_dat,
    input  logic [DATA_WIDTH-1:0] i_wbs_dat,
    output logic                  o_wbs_we,
    output logic                  o_wbs_stb,
    input  logic                  i_wbs_ack,
    output logic                  o_wbs_cyc,
    input  logic                  i_ren,
    input  logic                  i_wren,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_data_val,
    output logic                  o_done
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
    logic [DATA_WIDTH-1:0]   dat_q, dat_d;
    logic                    we_q, we_d;
    logic                    cyc_q, cyc_d;
    logic                    stb_q, stb_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic                    data_val_q, data_val_d;
    logic                    done_q, done_d;

    always_comb begin
        state_d    = state_q;
        adr_d      = adr_q;
        dat_d      = dat_q;
        we_d       = we_q;
        cyc_d      = cyc_q;
        stb_d      = stb_q;
        rdata_d    = rdata_q;
        data_val_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                // Write has priority when both requests arrive together.
                if (i_wren) begin
                    adr_d   = i_addr;
                    dat_d   = i_data;
                    we_d    = 1'b1;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = BUSY;
                end else if (i_ren) begin
                    adr_d   = i_addr;
                    we_d    = 1'b0;
                    cyc_d   = 1'b1;
                    stb_d   = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (i_wbs_ack) begin
                    if (!we_q) rdata_d = i_wbs_dat;
                    // Pulses are registered here so they line up with the DONE cycle.
                    data_val_d = !we_q;
                    done_d     = 1'b1;
                    we_d       = 1'b0;
                    cyc_d      = 1'b0;
                    stb_d      = 1'b0;
                    state_d    = DONE;
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            state_q    <= IDLE;
            adr_q      <= '0;
            dat_q      <= '0;
            we_q       <= 1'b0;
            cyc_q      <= 1'b0;
            stb_q      <= 1'b0;
            rdata_q    <= '0;
            data_val_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            adr_q      <= adr_d;
            dat_q      <= dat_d;
            we_q       <= we_d;
            cyc_q      <= cyc_d;
            stb_q      <= stb_d;
            rdata_q    <= rdata_d;
            data_val_q <= data_val_d;
            done_q     <= done_d;
        end
    end

    assign o_wbs_adr  = adr_q;
    assign o_wbs_dat  = dat_q;
    assign o_wbs_we   = we_q;
    assign o_wbs_cyc  = cyc_q;
    assign o_wbs_stb  = stb_q;
    assign o_data     = rdata_q;
    assign o_data_val = data_val_q;
    assign o_done     = done_q;

endmodule

// File: tb/tb_wb_single_master.sv
// Directed bench for wb_single_master with a small delayed-ack slave model.
module tb_wb_single_master;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] wbs_adr;
    logic [7:0] wbs_dat_o;
    logic [7:0] wbs_dat_i = 8'h00;
    logic       wbs_we, wbs_stb, wbs_cyc;
    logic       slv_ack = 1'b0;
    logic       tb_ack = 1'b0;
    logic       ren = 1'b0, wren = 1'b0;
    logic [7:0] wdata = 8'h00;
    logic [2:0] addr = 3'd0;
    logic [7:0] rdata;
    logic       data_val, done;

    wb_single_master #(.ADDR_WIDTH(3), .DATA_WIDTH(8)) dut (
        .i_clk(clk), .i_reset(rst_n),
        .o_wbs_adr(wbs_adr), .o_wbs_dat(wbs_dat_o), .i_wbs_dat(wbs_dat_i),
        .o_wbs_we(wbs_we), .o_wbs_stb(wbs_stb), .i_wbs_ack(slv_ack | tb_ack),
        .o_wbs_cyc(wbs_cyc), .i_ren(ren), .i_wren(wren), .i_data(wdata),
        .i_addr(addr), .o_data(rdata), .o_data_val(data_val), .o_done(done)
    );

    always #5 clk = ~clk;

    // Slave: registered ack after slv_dly extra cycles of strobe.
    int         slv_dly = 0;
    int         slv_cnt = 0;
    logic [7:0] rd_q[$];
    logic [2:0] wr_adr = 3'd0;
    logic [7:0] wr_dat = 8'h00;

    always @(posedge clk) begin
        slv_ack <= 1'b0;
        if (wbs_cyc && wbs_stb && !slv_ack) begin
            if (slv_cnt >= slv_dly) begin
                slv_ack <= 1'b1;
                slv_cnt <= 0;
                if (wbs_we) begin
                    wr_adr <= wbs_adr;
                    wr_dat <= wbs_dat_o;
                end else begin
                    wbs_dat_i <= (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
                end
            end else begin
                slv_cnt <= slv_cnt + 1;
            end
        end else if (!wbs_stb) begin
            slv_cnt <= 0;
        end
    end

    // Monitor: counts bus cycles, cyc-high cycles and output pulses.
    int         n_bus = 0, n_cyc = 0, n_done = 0, n_val = 0, n_bad = 0;
    logic [7:0] val_q[$];
    initial begin
        logic cyc_prev;
        cyc_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (wbs_cyc === 1'b1 && cyc_prev !== 1'b1) n_bus++;
            if (wbs_cyc === 1'b1) n_cyc++;
            if (done === 1'b1) n_done++;
            if (data_val === 1'b1) begin
                n_val++;
                val_q.push_back(rdata);
                if (done !== 1'b1) n_bad++;
            end
            cyc_prev = wbs_cyc;
        end
    end

    int n_chk = 0, n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    int b0, c0, d0, v0, q0;

    task automatic snap();
        b0 = n_bus; c0 = n_cyc; d0 = n_done; v0 = n_val; q0 = val_q.size();
    endtask

    initial begin
        // Reset with a write request pending
        rst_n = 1'b0; wren = 1'b1; addr = 3'd5; wdata = 8'h33;
        repeat (3) tick();
        check("rst_cyc", wbs_cyc, 0);
        check("rst_stb", wbs_stb, 0);
        check("rst_we", wbs_we, 0);
        check("rst_adr", wbs_adr, 0);
        check("rst_odata", rdata, 8'h00);
        check("rst_done", done, 0);
        check("rst_val", data_val, 0);
        snap();
        rst_n = 1'b1;
        tick();
        wren = 1'b0;
        check("post_rst_cyc", wbs_cyc, 1);
        check("post_rst_we", wbs_we, 1);
        check("post_rst_adr", wbs_adr, 5);
        check("post_rst_dat", wbs_dat_o, 8'h33);
        repeat (6) tick();
        check("post_rst_bus", n_bus - b0, 1);
        check("post_rst_done", n_done - d0, 1);
        check("post_rst_wr", {wr_adr, wr_dat}, {3'd5, 8'h33});

        // Single write, ack one cycle after strobe
        slv_dly = 0;
        snap();
        addr = 3'b010; wdata = 8'h80; wren = 1'b1;
        tick();
        wren = 1'b0;
        check("wr_adr", wbs_adr, 2);
        check("wr_dat", wbs_dat_o, 8'h80);
        check("wr_we", wbs_we, 1);
        check("wr_stb", wbs_stb, 1);
        repeat (6) tick();
        check("wr_bus", n_bus - b0, 1);
        check("wr_cyc_len", n_cyc - c0, 2);
        check("wr_done", n_done - d0, 1);
        check("wr_val", n_val - v0, 0);
        check("wr_odata", rdata, 8'h00);
        check("wr_slave", {wr_adr, wr_dat}, {3'd2, 8'h80});

        // Single read with delayed ack
        slv_dly = 3;
        rd_q.push_back(8'h5A);
        snap();
        addr = 3'b100; ren = 1'b1;
        tick();
        ren = 1'b0;
        check("rd_we", wbs_we, 0);
        check("rd_adr", wbs_adr, 4);
        repeat (10) tick();
        check("rd_bus", n_bus - b0, 1);
        check("rd_cyc_len", n_cyc - c0, 5);
        check("rd_done", n_done - d0, 1);
        check("rd_val", n_val - v0, 1);
        check("rd_odata", rdata, 8'h5A);
        check("rd_val_data", (val_q.size() > q0) ? val_q[q0] : 8'hXX, 8'h5A);

        // Held-read polling
        slv_dly = 0;
        rd_q.push_back(8'h02);
        rd_q.push_back(8'h00);
        snap();
        addr = 3'd1; ren = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (n_val >= v0 + 2) break;
        end
        ren = 1'b0;
        check("poll_reached", n_val - v0, 2);
        repeat (8) tick();
        check("poll_bus", n_bus - b0, 2);
        check("poll_done", n_done - d0, 2);
        check("poll_val", n_val - v0, 2);
        check("poll_data0", (val_q.size() > q0) ? val_q[q0] : 8'hXX, 8'h02);
        check("poll_data1", (val_q.size() > q0 + 1) ? val_q[q0 + 1] : 8'hXX, 8'h00);
        check("poll_odata", rdata, 8'h00);

        // Collision: write wins; a write pulse during BUSY is dropped
        slv_dly = 2;
        snap();
        addr = 3'd6; wdata = 8'hC3; ren = 1'b1; wren = 1'b1;
        tick();
        ren = 1'b0; wren = 1'b0;
        check("col_we", wbs_we, 1);
        tick();
        addr = 3'd7; wdata = 8'h11; wren = 1'b1;
        tick();
        wren = 1'b0;
        repeat (8) tick();
        check("col_bus", n_bus - b0, 1);
        check("col_done", n_done - d0, 1);
        check("col_val", n_val - v0, 0);
        check("col_slave", {wr_adr, wr_dat}, {3'd6, 8'hC3});

        // Reset mid-cycle, then a stray ack
        slv_dly = 20;
        snap();
        addr = 3'd3; ren = 1'b1;
        tick();
        ren = 1'b0;
        repeat (3) tick();
        check("mid_busy_cyc", wbs_cyc, 1);
        rst_n = 1'b0;
        tick();
        check("mid_cyc", wbs_cyc, 0);
        check("mid_stb", wbs_stb, 0);
        rst_n = 1'b1;
        tb_ack = 1'b1;
        tick();
        tb_ack = 1'b0;
        repeat (4) tick();
        check("mid_done", n_done - d0, 0);
        check("mid_val", n_val - v0, 0);
        check("mid_bus", n_bus - b0, 1);
        check("mid_idle_cyc", wbs_cyc, 0);
        check("val_without_done", n_bad, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/wb_single_master.md
Name: wb_single_master

Overview:
- Minimal single-transaction Wishbone classic master that turns one-cycle read/write requests from a local state machine into a single Wishbone bus cycle.
- Drives a Wishbone slave peripheral register file, for example the 3-bit-address, 8-bit-data I2C master core used by the user I/O poller.
- Reports completion with a one-cycle done pulse. For reads it also returns the captured data with a one-cycle valid pulse.
- One transaction in flight at a time; no pipelining, no bursts.

Parameters:
- ADDR_WIDTH, 3: Wishbone address width; also the width of the request address.
- DATA_WIDTH, 8: Wishbone data width; also the width of request and response data.

Ports:
- i_clk  in  1  single clock; all logic on its rising edge.
- i_reset  in  1  synchronous, active-low reset (0 = reset).
- o_wbs_adr  out  ADDR_WIDTH  Wishbone address (to slave ADR_I).
- o_wbs_dat  out  DATA_WIDTH  Wishbone write data (to slave DAT_I).
- i_wbs_dat  in  DATA_WIDTH  Wishbone read data (from slave DAT_O).
- o_wbs_we  out  1  write enable.
- o_wbs_stb  out  1  strobe.
- i_wbs_ack  in  1  slave acknowledge.
- o_wbs_cyc  out  1  cycle valid.
- i_ren  in  1  read request.
- i_wren  in  1  write request.
- i_data  in  DATA_WIDTH  write data for the request.
- i_addr  in  ADDR_WIDTH  register address for the request.
- o_data  out  DATA_WIDTH  last read data.
- o_data_val  out  1  one-cycle pulse: o_data was updated by a read.
- o_done  out  1  one-cycle pulse: transaction complete (read or write).

Behaviour:
- All outputs are registered.
- Reset (i_reset=0 at a clock edge):
  - state=IDLE.
  - o_wbs_cyc, o_wbs_stb, o_wbs_we = 0.
  - o_wbs_adr = 0, o_wbs_dat = 0.
  - o_data = 0, o_data_val = 0, o_done = 0.
  - Reset mid-transaction abandons the cycle immediately (cyc/stb low on the next cycle); no done pulse is produced.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - Requests are sampled only in this state.
  - If i_wren=1: latch i_addr into o_wbs_adr and i_data into o_wbs_dat; set o_wbs_we=1, o_wbs_cyc=1, o_wbs_stb=1; go to BUSY.
  - Else if i_ren=1: latch i_addr; set o_wbs_we=0, o_wbs_cyc=1, o_wbs_stb=1; go to BUSY.
  - Both requests high at once: the write wins and the read is dropped.
  - Requests arriving in BUSY or DONE are ignored, not queued.
- BUSY:
  - Hold adr/dat/we/cyc/stb stable until i_wbs_ack=1.
  - On ack: drive cyc=0, stb=0, we=0 next cycle; go to DONE.
  - On a read ack: capture i_wbs_dat into o_data at the same edge.
  - No timeout: an ack that never arrives hangs in BUSY until reset.
- DONE (exactly one cycle):
  - o_done=1.
  - o_data_val=1 only if the completed transaction was a read.
  - Go to IDLE. Requests are not accepted during DONE, so a requester still holding i_ren high this cycle does not launch a second read.
- o_done and o_data_val are 0 in every other cycle.
- o_data holds its value until the next read completes; writes never change it.
- Latency:
  - Request high at IDLE edge n → cyc/stb visible from cycle n+1.
  - Slave ack at edge m → cyc/stb low and o_done=1 in cycle m+1 → IDLE at m+2.
  - With a registered one-cycle-ack slave: request at n, ack at n+2, o_done at n+3, next request accepted at n+4.
- A level-held i_ren is re-accepted on each return to IDLE. Requesters that poll (e.g. status-register polling) hold i_ren high and sample o_data on o_data_val.

Test Plan:
- Reset: hold i_reset=0 for 3 cycles with i_wren=1 → cyc=stb=we=0, o_data=0, o_done=o_data_val=0; release → one write accepted on the first IDLE cycle.
- Single write, slave acking 1 cycle after stb: i_addr=3'b010, i_data=8'h80, i_wren pulsed 1 cycle → bus shows adr=2, dat=8'h80, we=1, cyc=stb=1 for 2 cycles; o_done=1 for exactly 1 cycle; o_data_val stays 0; o_data unchanged.
- Single read: slave returns 8'h5A at addr 3'b100 with ack delayed 4 cycles → cyc/stb held for 5 cycles with we=0; o_data=8'h5A, and o_data_val=o_done=1 together for one cycle.
- Held read polling: i_ren held high; slave returns 8'h02 then 8'h00 → two separate bus cycles, each followed by a DONE cycle with no request accepted; o_data_val pulses twice with 8'h02 then 8'h00; drop i_ren in the cycle after the second pulse → no third cycle.
- Collisions: i_ren=i_wren=1 in IDLE → a write cycle only. A new i_wren pulse during BUSY → ignored (exactly one bus cycle, one o_done).
- Reset mid-cycle: assert i_reset=0 while in BUSY before ack → cyc/stb low next cycle, no o_done; a later ack from the slave is ignored.
